ex_mdu: RTL and testbench

Iterative multiply/divide unit implementing the RV32M `funct3` operations. It is parametrised in operand width. The unit sits beside the combinational `ex` ALU in the execute stage and holds the pipeline through `stallreq_o` while a multi-cycle operation runs. When the operation finishes, it presents the result with the destination register for the EX/MEM latch.

---
 rtl/ex_mdu_pkg.sv | 26 ++
 rtl/ex_mdu.sv | 147 ++++++++++++++
 tb/tb_ex_mdu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV32M funct3 codes,
// FSM state encodings and stall levels.
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on a shared 2*WIDTH accumulator, holding the pipeline via stallreq_o.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             flush_i,
  output logic             stallreq_o,
  output logic             done_o,
  output logic             wreg_o,
  output logic [4:0]       rd_addr_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [1:0]       dbg_state_o
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  mdu_state_e       state_q;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [W2-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_res_q, neg_rem_q;
  logic [4:0]       rd_q, rd_addr_q;
  logic [WIDTH-1:0] rd_data_q;

  mdu_op_e          op_in;
  logic             a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] short_res;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [W2-1:0]    acc_d, prod;
  logic [WIDTH-1:0] fix_res;

  assign op_in = mdu_op_e'(op_i);

  always_comb begin
    a_sgn    = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) || (op_in == MDU_DIV) || (op_in == MDU_REM);
    b_sgn    = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
    a_neg    = a_sgn && rs1_i[WIDTH-1];
    b_neg    = b_sgn && rs2_i[WIDTH-1];
    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = op_i[2] && !op_i[0] && (rs1_i == MOST_NEG) && (rs2_i == '1);
    // op_i[1] separates REM/REMU from DIV/DIVU within the divide group.
    if (div_zero) short_res = op_i[1] ? rs1_i : '1;
    else          short_res = op_i[1] ? '0 : rs1_i;
  end

  // Divide shifts dividend bits (from a_q, MSB first) into the upper half and
  // collects quotient bits in the lower half; multiply uses a_q as the multiplier.
  always_comb begin
    rem_sh = {acc_q[W2-1:WIDTH], a_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, b_q};
    if (op_q[2]) begin
      acc_d = {(ge ? rem_sh[WIDTH-1:0] - b_q : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end else begin
      acc_d = {acc_q[W2-2:0], 1'b0} + (a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : {W2{1'b0}});
    end
  end

  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    unique case (op_q)
      MDU_MUL:                         fix_res = prod[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod[W2-1:WIDTH];
      MDU_DIV, MDU_DIVU:               fix_res = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      default:                         fix_res = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MDU_IDLE;
      op_q      <= MDU_MUL;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      state_q <= MDU_IDLE;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            if (div_zero || div_ovf) begin
              rd_data_q <= short_res;
              rd_addr_q <= rd_addr_i;
              state_q   <= MDU_DONE;
            end else begin
              op_q      <= op_in;
              rd_q      <= rd_addr_i;
              a_q       <= mag(rs1_i, a_sgn);
              b_q       <= mag(rs2_i, b_sgn);
              acc_q     <= '0;
              cnt_q     <= CNT_W'(WIDTH);
              neg_res_q <= (op_in != MDU_MUL) && (a_neg ^ b_neg);
              neg_rem_q <= op_i[2] && a_neg;
              state_q   <= MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= MDU_FIX;
        end
        MDU_FIX: begin
          rd_data_q <= fix_res;
          rd_addr_q <= rd_q;
          state_q   <= MDU_DONE;
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  // Handshake: a request is accepted when start_i && !flush_i in IDLE; the
  // stall covers that cycle through FIX, and drops in DONE as the result is valid.
  assign stallreq_o  = ((state_q == MDU_IDLE) && start_i && !flush_i) ||
                       (state_q == MDU_CALC) || (state_q == MDU_FIX) ? STOP : NO_STOP;
  assign done_o      = (state_q == MDU_DONE);
  assign wreg_o      = done_o;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed RV32M vectors, random operations
// against an arithmetic reference model, flush and mid-operation reset.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_addr_i;
  logic        stallreq_o, done_o, wreg_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [1:0]  dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  ex_mdu dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_addr_i(rd_addr_i), .flush_i(flush_i), .stallreq_o(stallreq_o), .done_o(done_o),
    .wreg_o(wreg_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit inject);
    int cyc, lat;
    bit got, stall_ok;
    logic [31:0] exp;
    lat = ref_lat(op, a, b);
    exp_q.push_back(ref_mdu(op, a, b));
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    #1 stall_ok = stallreq_o;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1; got = 0;
    while (cyc < 100 && !got) begin
      if (done_o) got = 1;
      else begin
        if (!stallreq_o) stall_ok = 0;
        if (inject && cyc == 5) begin
          start_i = 1'b1; op_i = 3'd0; rs1_i = $urandom; rs2_i = $urandom; rd_addr_i = 5'd31;
        end
        @(negedge clk);
        start_i = 1'b0;
        cyc++;
      end
    end
    exp = exp_q.pop_front();
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", cyc, lat);
      check("stall_until_done", 32'(stall_ok), 32'd1);
      check("stall_in_done", 32'(stallreq_o), 32'd0);
      check("wreg", 32'(wreg_o), 32'd1);
      check("rd_addr", 32'(rd_addr_o), 32'(rd));
      check("rd_data", rd_data_o, exp);
      @(negedge clk);
      check("done_pulse_width", 32'(done_o), 32'd0);
      check("rd_data_hold", rd_data_o, exp);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  d_op[12];
    logic [31:0] d_a[12];
    logic [31:0] d_b[12];
    d_op = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    d_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    d_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stallreq_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(d_op[i], d_a[i], d_b[i], 5'(i + 1), 1'b0);

    // Start together with flush in IDLE is dropped.
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4;
    #1 check("flush_start_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_state", 32'(dbg_state_o), 32'd0);
    check("flush_start_done", 32'(done_o), 32'd0);

    // Flush at cycle 10 of a DIV, new start at cycle 12.
    start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1234; rs2_i = 32'd5; rd_addr_i = 5'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_state", 32'(dbg_state_o), 32'd0);
    check("flush_stall", 32'(stallreq_o), 32'd0);
    check("flush_done", 32'(done_o), 32'd0);
    @(negedge clk);
    check("flush_no_late_done", 32'(done_o), 32'd0);
    run_op(3'd5, 32'd1000, 32'd7, 5'd10, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 5'($urandom_range(0, 31)), 1'b0);

    // Asynchronous reset in the middle of CALC.
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 1'b0);
    start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; rd_addr_i = 5'd4;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stallreq_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_wreg", 32'(wreg_o), 32'd0);
    check("mid_rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("mid_rst_rd_data", rd_data_o, 32'd0);
    check("mid_rst_state", 32'(dbg_state_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(done_o), 32'd0);

    // A start pulse during CALC must not disturb the running operation.
    run_op(3'd6, 32'hFFFF_FF85, 32'd10, 5'd21, 1'b1);
    run_op(3'd0, 32'h0001_0003, 32'h0002_0005, 5'd22, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
